addsub_acc_sequencer: RTL and testbench
=======================================

// Module: addsub_acc_sequencer
// PURPOSE
//  Command-driven accumulator controller that sits directly upstream/downstream of the 4-bit
//  adder-subtractor datapath: drives its A, B and M inputs, then captures its sum and carry-out.
//  Executes LOAD/ADD/SUB/MUL commands against an internal accumulator; MUL is repeated addition.
//  Returns the result with C/V/Z flags over a valid/ready response channel.
// PARAMETERS
//  WIDTH     4     datapath width; must equal the adder-subtractor width
//  CNT_W     4     MUL iteration-counter width; must be >= WIDTH
// PORTS
//  clk        in   1      single clock; all state changes on rising edge
//  rst        in   1      synchronous, active-high reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      sequencer can accept a command
//  cmd_op     in   2      00 LOAD, 01 ADD, 10 SUB, 11 MUL
//  cmd_data   in   WIDTH  operand; unsigned iteration count for MUL
//  add_a      out  WIDTH  to adder A
//  add_b      out  WIDTH  to adder B
//  add_m      out  1      to adder M (1 = subtract)
//  add_sum    in   WIDTH  from adder sum; combinational, same cycle
//  add_cout   in   1      from adder carryOut
//  rsp_valid  out  1      result valid
//  rsp_ready  in   1      consumer accepts result
//  rsp_acc    out  WIDTH  accumulator value
//  rsp_c      out  1      carry (ADD/MUL) or no-borrow (SUB)
//  rsp_v      out  1      signed overflow
//  rsp_z      out  1      accumulator == 0
// BEHAVIOUR
//  Reset: state=IDLE; acc, mcand, cnt, C, V = 0; rsp_valid=0; cmd_ready=1; add_a/add_b/add_m=0.
//  Reset has priority in every state; an in-flight command is dropped and its response is never issued.
//  FSM: IDLE -> EXEC -> (MUL_LOOP)* -> RESP -> IDLE.
//  - IDLE: cmd_ready=1. cmd_valid&cmd_ready latches op and data -> EXEC. No other state accepts commands.
//  - EXEC, single cycle:
//    - LOAD: acc<=data; C<=0; V<=0.
//    - ADD: add_a=acc, add_b=data, add_m=0; acc<=add_sum; C<=add_cout;
//      V<=(a[MSB]==b[MSB]) & (sum[MSB]!=a[MSB]).
//    - SUB: add_m=1, other drives as ADD; acc<=add_sum; C<=add_cout (1 = no borrow);
//      V<=(a[MSB]!=b[MSB]) & (sum[MSB]!=a[MSB]).
//    - MUL: mcand<=acc; cnt<=data; acc<=0; C<=0; V<=0.
//      Next state is MUL_LOOP if data!=0, else RESP.
//  - MUL_LOOP: add_a=acc, add_b=mcand, add_m=0; acc<=add_sum; C<=C|add_cout;
//    V<=V|add-overflow; cnt<=cnt-1. Exit to RESP when cnt==1. Result = acc_old*data mod 2^WIDTH.
//  - RESP: rsp_valid=1; rsp_* registered and stable until rsp_valid&rsp_ready -> IDLE.
//  Outside EXEC/MUL_LOOP, add_a, add_b and add_m are driven to 0.
//  rsp_z = (acc==0); rsp_acc/flags also reflect the last result while not valid.
//  Latency (handshake in cycle n): rsp_valid rises in cycle n+2 for LOAD/ADD/SUB and MUL with data=0;
//    in cycle n+2+data for MUL. Peak throughput is one command per 3 cycles.
//  Wrap-around is modulo 2^WIDTH; no saturation.
//  rsp_ready held high: RESP lasts one cycle; cmd_ready rises in the following cycle.
// STRUCTURE
//  Shared include addsub_defs.vh: op encodings (OP_LOAD/ADD/SUB/MUL), FSM state localparams.
//  Sub-module addsub_flags: combinational V/Z computation from a, b, m and sum; reused by other stages.
//  Adder-subtractor stays external; this block holds only control state and the accumulator.
// TESTING
//  1 LOAD 5, ADD 3 -> rsp_acc=8, C=0, V=1, Z=0; rsp_valid 2 cycles after each accept.
//  2 LOAD 3, SUB 5 -> acc=14 (0xE), C=0 (borrow), V=0; LOAD 5, SUB 5 -> acc=0, C=1, Z=1.
//  3 LOAD 3, MUL 6 -> acc=2 (18 mod 16), C=1; rsp_valid 8 cycles after accept.
//    MUL 0 -> acc=0, Z=1 at n+2.
//  4 Hold rsp_ready=0 for 5 cycles in RESP -> outputs stable, cmd_ready=0,
//    add_* = 0, extra cmd_valid ignored.
//  5 Assert rst during MUL_LOOP (LOAD 7, MUL 15) -> next cycle IDLE, acc=0,
//    rsp_valid=0; no stale response after reset.
//  6 Randomised LOAD/ADD/SUB/MUL stream with random rsp_ready, checked against a reference model.

Source files
------------

// File: rtl/addsub_acc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addsub_acc_sequencer_pkg
// Description : Command opcodes and sequencer state encodings shared by the
//               accumulator sequencer and its flag logic.
// Revision    : 1.0 - initial release
// ============================================================================
package addsub_acc_sequencer_pkg;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_MUL  = 2'b11;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_EXEC     = 2'd1;
    localparam logic [1:0] ST_MUL_LOOP = 2'd2;
    localparam logic [1:0] ST_RESP     = 2'd3;

endpackage
`default_nettype wire

// File: rtl/addsub_flags.sv
`default_nettype none
// ============================================================================
// Module      : addsub_flags
// Description : Signed-overflow and zero flags for one adder-subtractor pass.
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_flags #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_m,
    input  logic [WIDTH-1:0] i_sum,
    output logic             o_v,
    output logic             o_z
);

    logic w_a_msb;
    logic w_b_msb;
    logic w_s_msb;

    assign w_a_msb = i_a[WIDTH-1];
    assign w_b_msb = i_b[WIDTH-1];
    assign w_s_msb = i_sum[WIDTH-1];

    // Subtraction overflows only when operand signs differ; addition only when they match.
    assign o_v = (i_m ? (w_a_msb != w_b_msb) : (w_a_msb == w_b_msb)) & (w_s_msb != w_a_msb);
    assign o_z = (i_sum == '0);

endmodule
`default_nettype wire

// File: rtl/addsub_acc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : addsub_acc_sequencer
// Description : LOAD/ADD/SUB/MUL accumulator controller driving an external
//               adder-subtractor, returning the result over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_acc_sequencer
    import addsub_acc_sequencer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_m,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_acc,
    output logic             rsp_c,
    output logic             rsp_v,
    output logic             rsp_z
);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [CNT_W-1:0] r_cnt;
    logic             r_c;
    logic             r_v;
    logic             r_z;

    logic [WIDTH-1:0] w_add_a;
    logic [WIDTH-1:0] w_add_b;
    logic             w_add_m;
    logic             w_ovf;
    logic             w_sum_zero;

    // The adder is only steered during arithmetic cycles; otherwise its inputs rest at zero.
    always_comb begin
        w_add_a = '0;
        w_add_b = '0;
        w_add_m = 1'b0;
        if (r_state == ST_EXEC && (r_op == OP_ADD || r_op == OP_SUB)) begin
            w_add_a = r_acc;
            w_add_b = r_data;
            w_add_m = (r_op == OP_SUB);
        end else if (r_state == ST_MUL_LOOP) begin
            w_add_a = r_acc;
            w_add_b = r_mcand;
        end
    end

    addsub_flags #(
        .WIDTH (WIDTH)
    ) u_flags (
        .i_a   (w_add_a),
        .i_b   (w_add_b),
        .i_m   (w_add_m),
        .i_sum (add_sum),
        .o_v   (w_ovf),
        .o_z   (w_sum_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= OP_LOAD;
            r_data  <= '0;
            r_acc   <= '0;
            r_mcand <= '0;
            r_cnt   <= '0;
            r_c     <= 1'b0;
            r_v     <= 1'b0;
            r_z     <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_op    <= cmd_op;
                        r_data  <= cmd_data;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (r_op)
                        OP_LOAD: begin
                            r_acc   <= r_data;
                            r_c     <= 1'b0;
                            r_v     <= 1'b0;
                            r_z     <= (r_data == '0);
                            r_state <= ST_RESP;
                        end
                        OP_MUL: begin
                            r_mcand <= r_acc;
                            r_cnt   <= CNT_W'(r_data);
                            r_acc   <= '0;
                            r_c     <= 1'b0;
                            r_v     <= 1'b0;
                            r_z     <= 1'b1;
                            r_state <= (r_data != '0) ? ST_MUL_LOOP : ST_RESP;
                        end
                        default: begin
                            r_acc   <= add_sum;
                            r_c     <= add_cout;
                            r_v     <= w_ovf;
                            r_z     <= w_sum_zero;
                            r_state <= ST_RESP;
                        end
                    endcase
                end
                ST_MUL_LOOP: begin
                    // Carry and overflow are sticky across the repeated additions.
                    r_acc <= add_sum;
                    r_c   <= r_c | add_cout;
                    r_v   <= r_v | w_ovf;
                    r_z   <= w_sum_zero;
                    r_cnt <= r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_acc   = r_acc;
    assign rsp_c     = r_c;
    assign rsp_v     = r_v;
    assign rsp_z     = r_z;
    assign add_a     = w_add_a;
    assign add_b     = w_add_b;
    assign add_m     = w_add_m;

endmodule
`default_nettype wire

// File: tb/tb_addsub_acc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_addsub_acc_sequencer
// Description : Scoreboard bench for addsub_acc_sequencer with an external
//               adder-subtractor model and an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_acc_sequencer;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'd0;
    logic [WIDTH-1:0] cmd_data = '0;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_m;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [WIDTH-1:0] rsp_acc;
    logic             rsp_c;
    logic             rsp_v;
    logic             rsp_z;

    addsub_acc_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .add_a(add_a), .add_b(add_b), .add_m(add_m), .add_sum(add_sum), .add_cout(add_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_acc(rsp_acc),
        .rsp_c(rsp_c), .rsp_v(rsp_v), .rsp_z(rsp_z)
    );

    always #5 clk = ~clk;

    // External 4-bit adder-subtractor: B is inverted and carry-in set when M=1.
    logic [WIDTH:0] adder_full;
    always_comb begin
        adder_full = '0;
        if (add_m) adder_full = {1'b0, add_a} + {1'b0, ~add_b} + 5'd1;
        else       adder_full = {1'b0, add_a} + {1'b0, add_b};
    end
    assign add_sum  = adder_full[WIDTH-1:0];
    assign add_cout = adder_full[WIDTH];

    typedef struct {
        int acc;
        bit c;
        bit v;
        bit z;
        int rise;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   m_acc = 0;
    bit   m_c = 0;
    bit   m_v = 0;
    bit   rnd_ready = 0;
    bit   fixed_ready = 1;
    bit   prev_valid = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        rsp_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : fixed_ready;
    end

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int sgn(int x);
        return (x >= 8) ? x - 16 : x;
    endfunction

    // Reference model: plain modulo-16 arithmetic with two's-complement range checks.
    function automatic void model_push(int op, int d, int n);
        exp_t e;
        int   lat = 2;
        int   s;
        int   ss;
        int   part;
        case (op)
            0: begin
                m_acc = d; m_c = 0; m_v = 0;
            end
            1: begin
                s  = m_acc + d;
                ss = sgn(m_acc) + sgn(d);
                m_c = (s >= 16);
                m_v = (ss > 7 || ss < -8);
                m_acc = s % 16;
            end
            2: begin
                ss = sgn(m_acc) - sgn(d);
                m_c = (m_acc >= d);
                m_v = (ss > 7 || ss < -8);
                m_acc = (m_acc - d + 16) % 16;
            end
            default: begin
                m_c  = (m_acc * d >= 16);
                m_v  = 0;
                part = 0;
                for (int k = 0; k < d; k++) begin
                    ss = sgn(part) + sgn(m_acc);
                    if (ss > 7 || ss < -8) m_v = 1;
                    part = (part + m_acc) % 16;
                end
                m_acc = (m_acc * d) % 16;
                lat   = 2 + d;
            end
        endcase
        e.acc  = m_acc;
        e.c    = m_c;
        e.v    = m_v;
        e.z    = (m_acc == 0);
        e.rise = n + lat;
        exp_q.push_back(e);
    endfunction

    // Monitor: latency on each rising rsp_valid, contents on each accepted response.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_valid = 0;
        end else begin
            if (rsp_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: rsp_valid=1 with no pending command (cycle %0d)", cyc);
                end else begin
                    check("rsp_latency", cyc, exp_q[0].rise);
                end
            end
            if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rsp_acc", int'(rsp_acc), e.acc);
                check("rsp_c", int'(rsp_c), int'(e.c));
                check("rsp_v", int'(rsp_v), int'(e.v));
                check("rsp_z", int'(rsp_z), int'(e.z));
            end
            prev_valid = rsp_valid;
        end
    end

    // Called and returns just after a rising edge.
    task automatic send(input int op, input int d);
        int waited = 0;
        cmd_op    = op[1:0];
        cmd_data  = d[WIDTH-1:0];
        cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            check("cmd_ready_timeout", 0, 1);
            cmd_valid = 1'b0;
            @(posedge clk); #1;
        end else begin
            model_push(op, d, cyc);
            @(posedge clk); #1;
            cmd_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_cmd_ready", int'(cmd_ready), 1);
        check("reset_rsp_valid", int'(rsp_valid), 0);
        check("reset_acc", int'(rsp_acc), 0);
        check("reset_c", int'(rsp_c), 0);
        check("reset_v", int'(rsp_v), 0);
        check("reset_z", int'(rsp_z), 1);
        check("reset_add_a", int'(add_a), 0);
        check("reset_add_b", int'(add_b), 0);
        check("reset_add_m", int'(add_m), 0);
        @(posedge clk); #1;

        // Directed arithmetic: ADD overflow, SUB borrow / zero, MUL wrap and MUL 0.
        send(0, 5); send(1, 3);
        send(0, 3); send(2, 5);
        send(0, 5); send(2, 5);
        send(0, 3); send(3, 6);
        send(3, 0);
        drain();

        // Back-pressure: response held, extra commands ignored, adder idle.
        fixed_ready = 0;
        @(posedge clk); #1;
        send(0, 9);
        waited = 0;
        while (!rsp_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("hold_rsp_valid_seen", int'(rsp_valid), 1);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_data = 4'd1;
        repeat (5) begin
            @(negedge clk);
            check("hold_rsp_valid", int'(rsp_valid), 1);
            check("hold_cmd_ready", int'(cmd_ready), 0);
            check("hold_acc", int'(rsp_acc), 9);
            check("hold_add_a", int'(add_a), 0);
            check("hold_add_b", int'(add_b), 0);
            check("hold_add_m", int'(add_m), 0);
        end
        @(posedge clk); #1;
        cmd_valid   = 1'b0;
        fixed_ready = 1;
        drain();

        // Reset during the multiply loop drops the in-flight command.
        send(0, 7);
        send(3, 15);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        m_acc = 0; m_c = 0; m_v = 0;
        @(negedge clk);
        check("rst_mid_rsp_valid", int'(rsp_valid), 0);
        check("rst_mid_cmd_ready", int'(cmd_ready), 1);
        check("rst_mid_acc", int'(rsp_acc), 0);
        check("rst_mid_z", int'(rsp_z), 1);
        check("rst_mid_c", int'(rsp_c), 0);
        repeat (25) @(negedge clk);
        @(posedge clk); #1;

        // Randomised command stream with random back-pressure.
        rnd_ready = 1;
        repeat (80) begin
            send($urandom_range(0, 3), $urandom_range(0, 15));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        drain();
        rnd_ready = 0;
        fixed_ready = 1;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
